// File: rtl/cache_fence_seq.sv
// Sequences FENCE.I / full-flush requests into ordered dcache flush, dcache clear and icache clear handshakes.
// Registered outputs: first cache request one cycle after acceptance; a done pulse moves to the next step the following cycle.
module cache_fence_seq #(
  parameter bit DFLUSH_EN = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             fence_i_req,
  input  logic             flush_all_req,
  input  logic             dflush_done,
  input  logic             dclear_done,
  input  logic             iclear_done,
  output logic             dcache_flush,
  output logic             dcache_clear,
  output logic             icache_clear,
  output logic             fence_busy,
  output logic             fence_ack,
  output logic [CNT_W-1:0] last_fence_cycles
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DFLUSH = 3'd1,
    DCLEAR = 3'd2,
    ICLEAR = 3'd3,
    ACK    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               mode_all_q, mode_all_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   last_q, last_d;
  logic               dflush_q, dflush_d;
  logic               dclear_q, dclear_d;
  logic               iclear_q, iclear_d;
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;

  always_comb begin
    state_d    = state_q;
    mode_all_d = mode_all_q;
    cnt_d      = cnt_q;
    last_d     = last_q;

    unique case (state_q)
      IDLE: begin
        if (flush_all_req || fence_i_req) begin
          mode_all_d = flush_all_req;
          cnt_d      = '0;
          if (DFLUSH_EN)          state_d = DFLUSH;
          else if (flush_all_req) state_d = DCLEAR;
          else                    state_d = ICLEAR;
        end
      end
      DFLUSH: if (dflush_done) state_d = mode_all_q ? DCLEAR : ICLEAR;
      DCLEAR: if (dclear_done) state_d = ICLEAR;
      ICLEAR: if (iclear_done) state_d = ACK;
      ACK: begin
        last_d  = cnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Counts every cycle spent waiting on a cache, saturating at all-ones.
    if ((state_q == DFLUSH || state_q == DCLEAR || state_q == ICLEAR) && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);

    dflush_d = (state_d == DFLUSH);
    dclear_d = (state_d == DCLEAR);
    iclear_d = (state_d == ICLEAR);
    busy_d   = (state_d != IDLE);
    ack_d    = (state_d == ACK);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      mode_all_q <= 1'b0;
      cnt_q      <= '0;
      last_q     <= '0;
      dflush_q   <= 1'b0;
      dclear_q   <= 1'b0;
      iclear_q   <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_all_q <= mode_all_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      dflush_q   <= dflush_d;
      dclear_q   <= dclear_d;
      iclear_q   <= iclear_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
    end
  end

  assign dcache_flush      = dflush_q;
  assign dcache_clear      = dclear_q;
  assign icache_clear      = iclear_q;
  assign fence_busy        = busy_q;
  assign fence_ack         = ack_q;
  assign last_fence_cycles = last_q;

endmodule

// File: tb/tb_cache_fence_seq.sv
// Directed bench for cache_fence_seq: default, DFLUSH_EN=0 and CNT_W=4 instances share stimulus.
module tb_cache_fence_seq;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST, fence_i_req, flush_all_req, dflush_done, dclear_done, iclear_done;

  logic        f_a, d_a, i_a, busy_a, ack_a;
  logic [15:0] last_a;
  logic        f_b, d_b, i_b, busy_b, ack_b;
  logic [15:0] last_b;
  logic        f_c, d_c, i_c, busy_c, ack_c;
  logic [3:0]  last_c;

  cache_fence_seq u_a (
    .CLK(CLK), .RST(RST), .fence_i_req(fence_i_req), .flush_all_req(flush_all_req),
    .dflush_done(dflush_done), .dclear_done(dclear_done), .iclear_done(iclear_done),
    .dcache_flush(f_a), .dcache_clear(d_a), .icache_clear(i_a),
    .fence_busy(busy_a), .fence_ack(ack_a), .last_fence_cycles(last_a));

  cache_fence_seq #(.DFLUSH_EN(1'b0)) u_b (
    .CLK(CLK), .RST(RST), .fence_i_req(fence_i_req), .flush_all_req(flush_all_req),
    .dflush_done(dflush_done), .dclear_done(dclear_done), .iclear_done(iclear_done),
    .dcache_flush(f_b), .dcache_clear(d_b), .icache_clear(i_b),
    .fence_busy(busy_b), .fence_ack(ack_b), .last_fence_cycles(last_b));

  cache_fence_seq #(.CNT_W(4)) u_c (
    .CLK(CLK), .RST(RST), .fence_i_req(fence_i_req), .flush_all_req(flush_all_req),
    .dflush_done(dflush_done), .dclear_done(dclear_done), .iclear_done(iclear_done),
    .dcache_flush(f_c), .dcache_clear(d_c), .icache_clear(i_c),
    .fence_busy(busy_c), .fence_ack(ack_c), .last_fence_cycles(last_c));

  int   sel;
  logic o_f, o_d, o_i, o_busy, o_ack;
  int   o_last;

  always_comb begin
    o_f = f_a; o_d = d_a; o_i = i_a; o_busy = busy_a; o_ack = ack_a; o_last = int'(last_a);
    if (sel == 1) begin
      o_f = f_b; o_d = d_b; o_i = i_b; o_busy = busy_b; o_ack = ack_b; o_last = int'(last_b);
    end else if (sel == 2) begin
      o_f = f_c; o_d = d_c; o_i = i_c; o_busy = busy_c; o_ack = ack_c; o_last = int'(last_c);
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; fence_i_req = 1'b0; flush_all_req = 1'b0;
    dflush_done = 1'b0; dclear_done = 1'b0; iclear_done = 1'b0;
    step(); step();
    RST = 1'b0;
  endtask

  int n_f, n_d, n_i, n_ack, n_ovl, t_f, t_d, t_i, t_ack, busy_after;

  // Cache model: each done pulses in the Nth cycle its request is high.
  task automatic run_seq(input bit fi, input bit all, input int df, input int dd, input int di,
                         input bit stray, input bit drop_early);
    int  af, ad, ai, cyc;
    bit  fin;
    af = 0; ad = 0; ai = 0; cyc = 0; fin = 0;
    n_f = 0; n_d = 0; n_i = 0; n_ack = 0; n_ovl = 0;
    t_f = -1; t_d = -1; t_i = -1; t_ack = -1; busy_after = -1;
    fence_i_req = fi; flush_all_req = all;
    while (!fin && cyc < 200) begin
      step(); cyc++;
      dflush_done = 1'b0; dclear_done = 1'b0; iclear_done = 1'b0;
      if (drop_early && cyc == 1) begin
        fence_i_req = 1'b0; flush_all_req = 1'b0;
      end
      af = o_f ? af + 1 : 0;
      ad = o_d ? ad + 1 : 0;
      ai = o_i ? ai + 1 : 0;
      if (o_f) begin n_f++; if (t_f < 0) t_f = cyc; end
      if (o_d) begin n_d++; if (t_d < 0) t_d = cyc; end
      if (o_i) begin n_i++; if (t_i < 0) t_i = cyc; end
      if (int'(o_f) + int'(o_d) + int'(o_i) > 1) n_ovl++;
      if (o_f && af == df) dflush_done = 1'b1;
      if (o_f && stray && af == 1) iclear_done = 1'b1;
      if (o_d && ad == dd) dclear_done = 1'b1;
      if (o_i && ai == di) iclear_done = 1'b1;
      if (o_ack) begin
        n_ack++; t_ack = cyc;
        fence_i_req = 1'b0; flush_all_req = 1'b0;
        step(); cyc++;
        if (o_ack) n_ack++;
        busy_after = int'(o_busy);
        fin = 1;
      end
    end
    if (!fin) check("sequence_timeout", cyc, -1);
  endtask

  initial begin
    sel = 0;
    fence_i_req = 1'b1; flush_all_req = 1'b0;
    dflush_done = 1'b0; dclear_done = 1'b0; iclear_done = 1'b0;
    RST = 1'b1;
    step(); step();
    check("rst_flush", int'(o_f), 0);
    check("rst_req_any", int'(o_d | o_i), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_ack", int'(o_ack), 0);
    check("rst_last", o_last, 0);
    RST = 1'b0;
    step();
    check("rel_flush", int'(o_f), 1);
    check("rel_busy", int'(o_busy), 1);

    // FENCE.I, 3-cycle cache responses
    do_reset();
    run_seq(1'b1, 1'b0, 3, 0, 3, 1'b0, 1'b0);
    check("fi_nflush", n_f, 3);
    check("fi_niclear", n_i, 3);
    check("fi_ndclear", n_d, 0);
    check("fi_nack", n_ack, 1);
    check("fi_tack", t_ack, 7);
    check("fi_busy_after", busy_after, 0);
    check("fi_last", o_last, 6);

    // Simultaneous requests, minimum latency, requests dropped mid-sequence
    do_reset();
    run_seq(1'b1, 1'b1, 2, 2, 2, 1'b0, 1'b1);
    check("all_overlap", n_ovl, 0);
    check("all_tflush", t_f, 1);
    check("all_tdclear", t_d, 3);
    check("all_ticlear", t_i, 5);
    check("all_tack", t_ack, 7);
    check("all_last", o_last, 6);

    // Stray iclear_done during DFLUSH must be ignored
    do_reset();
    run_seq(1'b1, 1'b0, 3, 0, 2, 1'b1, 1'b0);
    check("stray_ticlear", t_i, 4);
    check("stray_niclear", n_i, 2);
    check("stray_tack", t_ack, 6);
    check("stray_last", o_last, 5);
    step();
    check("last_hold", o_last, 5);
    RST = 1'b1;
    step();
    check("rst_clears_last", o_last, 0);
    RST = 1'b0;

    // DFLUSH_EN=0
    sel = 1;
    do_reset();
    run_seq(1'b1, 1'b0, 1, 0, 2, 1'b0, 1'b0);
    check("nodf_fi_nflush", n_f, 0);
    check("nodf_fi_tack", t_ack, 3);
    check("nodf_fi_last", o_last, 2);
    do_reset();
    run_seq(1'b0, 1'b1, 1, 2, 2, 1'b0, 1'b0);
    check("nodf_all_nflush", n_f, 0);
    check("nodf_all_tdclear", t_d, 1);
    check("nodf_all_tack", t_ack, 5);

    // Counter saturation with CNT_W=4
    sel = 2;
    do_reset();
    run_seq(1'b1, 1'b0, 30, 0, 2, 1'b0, 1'b0);
    check("sat_tack", t_ack, 33);
    check("sat_last", o_last, 15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
